// File: rtl/ul_cmp_sched_pkg.sv
// Shared types and constants for the uplink compression scheduler.
// State encoding, lane-index width helper, metadata widths, error bits.
package ul_cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT,
    XFER,
    GAP
  } state_t;

  localparam int SLOT_W = 7;
  localparam int SYMB_W = 4;
  localparam int PRB_W  = 9;
  localparam int TYPE_W = 4;

  localparam int ERR_VLD = 0;
  localparam int ERR_POS = 1;

  function automatic int lane_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ul_cmp_sched_arb.sv
// Mask-based round-robin arbiter: lowest requester above the last
// winner, else lowest requester overall; pointer moves on advance.
import ul_cmp_sched_pkg::*;

module ul_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = lane_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  mask;
  logic [N-1:0]  pool;

  // pick the first requester after the pointer, wrapping around
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (i > int'(ptr));
    pool = ((req & mask) != '0) ? (req & mask) : req;
    gnt  = '0;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pool[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
  end

  // last-winner pointer; reset value makes lane 0 win first
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= IW'(N - 1);
    else if (advance && (|req))
      ptr <= idx;
  end

endmodule

// File: rtl/ul_compress_sched.sv
// Round-robin PRB-burst scheduler in front of the BFP compressor.
// Optional per-lane burst counters: define UL_CMP_SCHED_STAT_EN.
import ul_cmp_sched_pkg::*;

module ul_compress_sched #(
  parameter int NUM_REQ = 4,
  parameter int PRB_LEN = 24,
  parameter int GAP_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic [NUM_REQ-1:0]          i_req,
  output logic [NUM_REQ-1:0]          o_gnt,
  input  logic [NUM_REQ-1:0]          i_vld,
  input  logic [NUM_REQ-1:0]          i_sop,
  input  logic [NUM_REQ-1:0]          i_eop,
  input  logic [NUM_REQ-1:0]          i_sel,
  input  logic [32*NUM_REQ-1:0]       i_din,
  input  logic [SLOT_W*NUM_REQ-1:0]   i_slot_idx,
  input  logic [SYMB_W*NUM_REQ-1:0]   i_symb_idx,
  input  logic [PRB_W*NUM_REQ-1:0]    i_prb_idx,
  input  logic [TYPE_W*NUM_REQ-1:0]   i_ch_type,
  input  logic                        i_err_clr,
  output logic                        o_sel,
  output logic                        o_sop,
  output logic                        o_eop,
  output logic                        o_vld,
  output logic [31:0]                 o_din,
  output logic [SLOT_W-1:0]           o_slot_idx,
  output logic [SYMB_W-1:0]           o_symb_idx,
  output logic [PRB_W-1:0]            o_prb_idx,
  output logic [TYPE_W-1:0]           o_type,
  output logic [7:0]                  o_info,
  output logic                        o_busy,
  output logic [1:0]                  o_err
`ifdef UL_CMP_SCHED_STAT_EN
  ,
  output logic [16*NUM_REQ-1:0]       o_prb_cnt
`endif
);

  localparam int LANE_W = lane_w(NUM_REQ);
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRB_LEN - 1);
  localparam logic [CNT_W-1:0] GLST = CNT_W'(GAP_CYC - 1);

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [LANE_W-1:0]   arb_idx;
  logic                start;
  logic                cap;
  logic [CNT_W-1:0]    beat;
  logic [1:0]          err_set;

  assign start = (state == IDLE) && i_en && (|i_req);
  assign cap   = (state == GNT) || ((state == XFER) && (cnt != LAST));
  assign beat  = (state == GNT) ? '0 : cnt + 1'b1;

  ul_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (LANE_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_req),
    .advance (start),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  // flag checks on the beat being captured from the granted lane
  always_comb begin
    err_set = '0;
    if (cap) begin
      err_set[ERR_VLD] = !i_vld[lane];
      err_set[ERR_POS] = (i_sop[lane] != (beat == '0)) ||
                         (i_eop[lane] != (beat == LAST));
    end
  end

  // burst FSM with registered lane mux and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= '0;
      cnt        <= '0;
      o_gnt      <= '0;
      o_sel      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_vld      <= 1'b0;
      o_din      <= '0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_prb_idx  <= '0;
      o_type     <= '0;
      o_info     <= '0;
      o_busy     <= 1'b0;
      o_err      <= '0;
    end else begin
      o_gnt      <= '0;
      o_err      <= (o_err & ~{2{i_err_clr}}) | err_set;
      o_sel      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_vld      <= 1'b0;
      o_din      <= '0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_prb_idx  <= '0;
      o_type     <= '0;
      o_info     <= '0;
      if (cap) begin
        o_sel      <= i_sel[lane];
        o_sop      <= (beat == '0);
        o_eop      <= (beat == LAST);
        o_vld      <= i_vld[lane];
        o_din      <= i_din[32*lane +: 32];
        o_slot_idx <= i_slot_idx[SLOT_W*lane +: SLOT_W];
        o_symb_idx <= i_symb_idx[SYMB_W*lane +: SYMB_W];
        o_prb_idx  <= i_prb_idx[PRB_W*lane +: PRB_W];
        o_type     <= i_ch_type[TYPE_W*lane +: TYPE_W];
        o_info     <= {{(8-LANE_W){1'b0}}, lane};
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            o_gnt  <= arb_gnt;
            lane   <= arb_idx;
            o_busy <= 1'b1;
            state  <= GNT;
          end
        end
        GNT: begin
          cnt   <= '0;
          state <= XFER;
        end
        XFER: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GLST) begin
            cnt    <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UL_CMP_SCHED_STAT_EN
  // per-lane wrapping count of bursts, bumped on the eop beat
  always_ff @(posedge clk) begin
    if (rst)
      o_prb_cnt <= '0;
    else if (cap && (beat == LAST))
      o_prb_cnt[16*lane +: 16] <= o_prb_cnt[16*lane +: 16] + 16'd1;
  end
`endif

endmodule
